// File: rtl/host_regfile_pkg.sv
// host_regfile_pkg: shared FSM state type, register byte offsets and CTRL bit positions.
package host_regfile_pkg;
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    localparam logic [7:0] CTRL_ADDR   = 8'h00;
    localparam logic [7:0] CYCLES_ADDR = 8'h04;
    localparam logic [7:0] LENGTH_ADDR = 8'h08;
    localparam logic [7:0] INP_LO_ADDR = 8'h0C;
    localparam logic [7:0] INP_HI_ADDR = 8'h10;
    localparam logic [7:0] OUT_LO_ADDR = 8'h14;
    localparam logic [7:0] OUT_HI_ADDR = 8'h18;
    localparam int CTRL_LAUNCH_BIT = 0;
    localparam int CTRL_DONE_BIT   = 1;
endpackage

// File: rtl/host_regfile_ecnt.sv
// host_regfile_ecnt: wrapping run-time cycle counter with synchronous clear and count enable.
module host_regfile_ecnt #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q, count_d;

    always_comb count_d = clr ? '0 : en ? count_q + 1'b1 : count_q;

    always_ff @(posedge clock or negedge reset)
        if (!reset) count_q <= '0;
        else        count_q <= count_d;

    assign count = count_q;
endmodule

// File: rtl/host_regfile.sv
// host_regfile: host CSR block driving the add-by-one compute stage.
// Define HOST_REGFILE_ECNT_EN to build the CYCLES run-time counter; otherwise CYCLES reads 0.
module host_regfile
    import host_regfile_pkg::*;
#(
    parameter int HOST_ADDR_BITS = 8,
    parameter int HOST_DATA_BITS = 32,
    parameter int MEM_ADDR_BITS  = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      host_req_valid,
    input  logic                      host_req_opcode,
    input  logic [HOST_ADDR_BITS-1:0] host_req_addr,
    input  logic [HOST_DATA_BITS-1:0] host_req_value,
    output logic                      host_req_deq,
    output logic                      host_resp_valid,
    output logic [HOST_DATA_BITS-1:0] host_resp_bits,
    output logic                      launch,
    input  logic                      finish,
    output logic [HOST_DATA_BITS-1:0] length,
    output logic [MEM_ADDR_BITS-1:0]  inp_baddr,
    output logic [MEM_ADDR_BITS-1:0]  out_baddr
);
    state_t state_q, state_d;
    logic launch_q, launch_d, done_q, done_d;
    logic [HOST_DATA_BITS-1:0] length_q, length_d, rdata_q, rdata_d, rdata, cycles;
    logic [HOST_DATA_BITS-1:0] inp_lo_q, inp_lo_d, inp_hi_q, inp_hi_d;
    logic [HOST_DATA_BITS-1:0] out_lo_q, out_lo_d, out_hi_q, out_hi_d;
    logic wr, wr_ctrl;

    assign host_req_deq = state_q == IDLE && host_req_valid;
    assign wr           = host_req_deq && host_req_opcode;
    assign wr_ctrl      = wr && host_req_addr == CTRL_ADDR;

`ifdef HOST_REGFILE_ECNT_EN
    logic cnt_clr, cnt_en;
    // Clear only on a genuine 0->1 launch edge; a colliding finish suppresses it.
    assign cnt_clr = wr_ctrl && host_req_value[CTRL_LAUNCH_BIT] && !launch_q && !finish;
    assign cnt_en  = launch_q && !finish;
    host_regfile_ecnt #(.W(HOST_DATA_BITS)) u_ecnt (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (cycles)
    );
`else
    assign cycles = '0;
`endif

    always_comb begin
        rdata = '0;
        case (host_req_addr)
            CTRL_ADDR: begin
                rdata[CTRL_LAUNCH_BIT] = launch_q;
                rdata[CTRL_DONE_BIT]   = done_q;
            end
            CYCLES_ADDR: rdata = cycles;
            LENGTH_ADDR: rdata = length_q;
            INP_LO_ADDR: rdata = inp_lo_q;
            INP_HI_ADDR: rdata = inp_hi_q;
            OUT_LO_ADDR: rdata = out_lo_q;
            OUT_HI_ADDR: rdata = out_hi_q;
            default:     rdata = '0;
        endcase
    end

    always_comb begin
        length_d = length_q;
        inp_lo_d = inp_lo_q;
        inp_hi_d = inp_hi_q;
        out_lo_d = out_lo_q;
        out_hi_d = out_hi_q;
        state_d  = host_req_deq ? (host_req_opcode ? WRITE : READ) : IDLE;
        rdata_d  = (host_req_deq && !host_req_opcode) ? rdata : '0;
        launch_d = finish ? 1'b0 : wr_ctrl ? host_req_value[CTRL_LAUNCH_BIT] : launch_q;
        done_d   = finish ? 1'b1 : wr_ctrl ? 1'b0 : done_q;
        // Configuration is frozen for the duration of a run.
        if (wr && !launch_q) begin
            case (host_req_addr)
                LENGTH_ADDR: length_d = host_req_value;
                INP_LO_ADDR: inp_lo_d = host_req_value;
                INP_HI_ADDR: inp_hi_d = host_req_value;
                OUT_LO_ADDR: out_lo_d = host_req_value;
                OUT_HI_ADDR: out_hi_d = host_req_value;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            launch_q <= 1'b0;
            done_q   <= 1'b0;
            rdata_q  <= '0;
            length_q <= '0;
            inp_lo_q <= '0;
            inp_hi_q <= '0;
            out_lo_q <= '0;
            out_hi_q <= '0;
        end else begin
            state_q  <= state_d;
            launch_q <= launch_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            length_q <= length_d;
            inp_lo_q <= inp_lo_d;
            inp_hi_q <= inp_hi_d;
            out_lo_q <= out_lo_d;
            out_hi_q <= out_hi_d;
        end
    end

    assign host_resp_valid = state_q == READ;
    assign host_resp_bits  = rdata_q;
    assign launch          = launch_q;
    assign length          = length_q;
    assign inp_baddr       = MEM_ADDR_BITS'({inp_hi_q, inp_lo_q});
    assign out_baddr       = MEM_ADDR_BITS'({out_hi_q, out_lo_q});
endmodule

// File: tb/tb_host_regfile.sv
// tb_host_regfile: directed plus random host traffic against a register-level reference model;
// read responses are checked by a queue-based scoreboard monitor.
module tb_host_regfile;
    logic        clock = 1'b0, reset = 1'b0;
    logic        valid = 1'b0, opcode = 1'b0, fin = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] value = '0;
    logic        host_req_deq, host_resp_valid, launch;
    logic [31:0] host_resp_bits, length;
    logic [63:0] inp_baddr, out_baddr;

    host_regfile dut (
        .clock           (clock),
        .reset           (reset),
        .host_req_valid  (valid),
        .host_req_opcode (opcode),
        .host_req_addr   (addr),
        .host_req_value  (value),
        .host_req_deq    (host_req_deq),
        .host_resp_valid (host_resp_valid),
        .host_resp_bits  (host_resp_bits),
        .launch          (launch),
        .finish          (fin),
        .length          (length),
        .inp_baddr       (inp_baddr),
        .out_baddr       (out_baddr)
    );

    always #5 clock = ~clock;

    int checks = 0, errors = 0, n_resp = 0;
    logic [31:0] exp_q[$];

    // Reference model: architectural register contents, indexed by word address.
    logic        m_launch, m_done, m_busy;
    logic [31:0] m_cycles;
    logic [31:0] m_cfg[2:6];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_launch = 0; m_done = 0; m_busy = 0; m_cycles = 0;
        for (int i = 2; i <= 6; i++) m_cfg[i] = 0;
    endtask

    function automatic logic [31:0] model_read(logic [7:0] a);
        int idx;
        idx = int'(a[4:2]);
        if (a[1:0] != 2'b00 || a > 8'h18) return 32'h0;
        if (idx == 0) return {30'b0, m_done, m_launch};
`ifdef HOST_REGFILE_ECNT_EN
        if (idx == 1) return m_cycles;
`else
        if (idx == 1) return 32'h0;
`endif
        return m_cfg[idx];
    endfunction

    // One clock cycle with the currently driven inputs; starts and ends 1 time unit after a posedge.
    task automatic tick();
        logic dq, wr;
        int idx;
        dq = valid && !m_busy;
        #1 chk("deq", {63'b0, host_req_deq}, {63'b0, dq});
        wr  = dq && opcode;
        idx = int'(addr[4:2]);
        if (dq && !opcode) exp_q.push_back(model_read(addr));
        if (wr && addr == 8'h00 && value[0] && !m_launch && !fin) m_cycles = 0;
        else if (m_launch && !fin) m_cycles = m_cycles + 1;
        if (wr && !m_launch && addr[1:0] == 2'b00 && addr >= 8'h08 && addr <= 8'h18) m_cfg[idx] = value;
        if (fin) begin m_launch = 0; m_done = 1; end
        else if (wr && addr == 8'h00) begin m_launch = value[0]; m_done = 0; end
        m_busy = dq;
        @(posedge clock);
        #1;
        chk("launch", {63'b0, launch}, {63'b0, m_launch});
        chk("length", {32'b0, length}, {32'b0, m_cfg[2]});
        chk("inp_baddr", inp_baddr, {m_cfg[4], m_cfg[3]});
        chk("out_baddr", out_baddr, {m_cfg[6], m_cfg[5]});
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr_req(logic [7:0] a, logic [31:0] v);
        valid = 1; opcode = 1; addr = a; value = v;
        tick();
        valid = 0;
        tick();
    endtask

    task automatic rd_req(logic [7:0] a);
        valid = 1; opcode = 0; addr = a;
        tick();
        valid = 0;
        tick();
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (host_resp_valid) begin
                n_resp++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected: got %0h expected no response at %0t", host_resp_bits, $time);
                end else chk("resp_bits", {32'b0, host_resp_bits}, {32'b0, exp_q.pop_front()});
            end else chk("resp_idle_zero", {32'b0, host_resp_bits}, 64'h0);
        end
    end

    logic [7:0] addrs[9] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h40, 8'h0D};

    initial begin
        int n0;
        model_reset();
        #12;
        chk("reset_launch", {63'b0, launch}, 64'h0);
        chk("reset_resp_valid", {63'b0, host_resp_valid}, 64'h0);
        chk("reset_length", {32'b0, length}, 64'h0);
        reset = 1;
        @(posedge clock);
        #1;
        // Configuration
        wr_req(8'h08, 32'd16);
        wr_req(8'h0C, 32'h1000);
        wr_req(8'h10, 32'h1);
        wr_req(8'h14, 32'h2000);
        wr_req(8'h18, 32'h0);
        chk("cfg_length", {32'b0, length}, 64'd16);
        chk("cfg_inp", inp_baddr, 64'h1_0000_1000);
        chk("cfg_out", out_baddr, 64'h2000);
        rd_req(8'h0C);
        // Run of 10 counted cycles with a frozen LENGTH write in the middle
        wr_req(8'h00, 32'h1);
        wr_req(8'h08, 32'd99);
        chk("freeze_length", {32'b0, length}, 64'd16);
        idle(7);
        fin = 1;
        tick();
        fin = 0;
        chk("launch_after_finish", {63'b0, launch}, 64'h0);
        rd_req(8'h00);
        rd_req(8'h04);
        // finish colliding with a CTRL launch write
        valid = 1; opcode = 1; addr = 8'h00; value = 32'h1; fin = 1;
        tick();
        valid = 0; fin = 0;
        tick();
        chk("collision_launch", {63'b0, launch}, 64'h0);
        rd_req(8'h00);
        // Unmapped and unaligned reads
        n0 = n_resp;
        rd_req(8'h40);
        idle(2);
        chk("unmapped_resp_count", 64'(n_resp - n0), 64'd1);
        rd_req(8'h0D);
        // Back-to-back pending requests
        valid = 1; opcode = 0; addr = 8'h08;
        idle(4);
        valid = 0;
        idle(2);
        // Asynchronous reset mid-run
        wr_req(8'h00, 32'h1);
        idle(4);
        #1 reset = 0;
        #1;
        chk("arst_launch", {63'b0, launch}, 64'h0);
        chk("arst_resp_valid", {63'b0, host_resp_valid}, 64'h0);
        chk("arst_length", {32'b0, length}, 64'h0);
        chk("arst_inp", inp_baddr, 64'h0);
        model_reset();
        #1 reset = 1;
        @(posedge clock);
        #1;
        rd_req(8'h04);
        rd_req(8'h00);
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            valid  = 1'($urandom_range(0, 1));
            opcode = 1'($urandom_range(0, 1));
            addr   = addrs[$urandom_range(0, 8)];
            value  = $urandom;
            fin    = !fin && $urandom_range(0, 9) == 0;
            tick();
        end
        valid = 0; fin = 0;
        idle(3);
        chk("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
